// File: rtl/exec_alu_param.sv
// exec_alu_param: parametrised execute-stage ALU for the five-stage pipeline.
// Registered result with persistent carry/zero/negative flags and a
// valid/ready handshake toward Decode. Single-cycle ops complete in one cycle.
// Opcode 1111 is handled in one of two ways:
// - With EXEC_ALU_MUL_EN defined, it runs a WIDTH-cycle shift-add multiplier
//   that holds in_ready low while it is busy.
// - Without EXEC_ALU_MUL_EN, it behaves as a NOP.
module exec_alu_param #(
    parameter int WIDTH   = 16,
    parameter int SH_BITS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             busy
);

    localparam logic [3:0] OP_LDD  = 4'b0001;
    localparam logic [3:0] OP_STD  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_INC  = 4'b1001;
    localparam logic [3:0] OP_DEC  = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_SETC = 4'b1101;
    localparam logic [3:0] OP_CLRC = 4'b1110;
`ifdef EXEC_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1111;
    localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               c_q, c_d;
    logic               z_q, z_d;
    logic               n_q, n_d;

    // Single-cycle datapath results, computed straight from the operands
    // presented at the accepting edge so they are captured with the op.
    logic [SH_BITS-1:0] sh_amt;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     inc_w;
    logic [WIDTH:0]     dec_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic [WIDTH-1:0]   op_res;
    logic               op_c;
    logic               op_zn;

`ifdef EXEC_ALU_MUL_EN
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_step;
`endif

    // Zero flag of a result word.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    // Negative flag of a result word (its top bit).
    function automatic logic sign_of(input logic [WIDTH-1:0] v);
        return v[WIDTH-1];
    endfunction

    // Wide arithmetic: bit WIDTH of each vector is the carry/borrow out.
    always_comb begin
        sh_amt = b[SH_BITS-1:0];
        add_w  = {1'b0, a} + {1'b0, b};
        sub_w  = {1'b0, a} - {1'b0, b};
        inc_w  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        dec_w  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
        // SHL: the last bit pushed out lands in bit WIDTH; zero for amount 0.
        shl_w  = {1'b0, a} << sh_amt;
        // SHR: the last bit pushed out lands in bit 0; zero for amount 0.
        shr_w  = {a, 1'b0} >> sh_amt;
    end

    // Opcode decode for the single-cycle ops; defaults leave state untouched.
    always_comb begin
        op_res = result_q;
        op_c   = c_q;
        op_zn  = 1'b0;
        unique case (func)
            OP_LDD, OP_STD: begin
                op_res = a;
            end
            OP_ADD: begin
                op_res = add_w[WIDTH-1:0];
                op_c   = add_w[WIDTH];
                op_zn  = 1'b1;
            end
            OP_SUB: begin
                op_res = sub_w[WIDTH-1:0];
                op_c   = sub_w[WIDTH];
                op_zn  = 1'b1;
            end
            OP_AND: begin
                op_res = a & b;
                op_zn  = 1'b1;
            end
            OP_OR: begin
                op_res = a | b;
                op_zn  = 1'b1;
            end
            OP_NOT: begin
                op_res = ~b;
                op_zn  = 1'b1;
            end
            OP_INC: begin
                op_res = inc_w[WIDTH-1:0];
                op_c   = inc_w[WIDTH];
                op_zn  = 1'b1;
            end
            OP_DEC: begin
                op_res = dec_w[WIDTH-1:0];
                op_c   = dec_w[WIDTH];
                op_zn  = 1'b1;
            end
            OP_SHL: begin
                op_res = shl_w[WIDTH-1:0];
                op_c   = shl_w[WIDTH];
                op_zn  = 1'b1;
            end
            OP_SHR: begin
                op_res = shr_w[WIDTH:1];
                op_c   = shr_w[0];
                op_zn  = 1'b1;
            end
            OP_SETC: begin
                op_c   = 1'b1;
            end
            OP_CLRC: begin
                op_c   = 1'b0;
            end
            default: begin
                // NOP encodings (and 1111 when the multiplier is absent).
            end
        endcase
    end

    // Next-state, result and flag update: flush beats everything, a running
    // multiply blocks new work, otherwise accept whatever Decode offers.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        n_d      = n_q;
`ifdef EXEC_ALU_MUL_EN
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`endif
        if (flush) begin
            state_d = ST_IDLE;
        end
`ifdef EXEC_ALU_MUL_EN
        else if (state_q == ST_MUL) begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                result_d = prod_step[WIDTH-1:0];
                c_d      = |prod_step[2*WIDTH-1:WIDTH];
                z_d      = is_zero(prod_step[WIDTH-1:0]);
                n_d      = sign_of(prod_step[WIDTH-1:0]);
                state_d  = ST_EXEC;
            end
        end
`endif
        else if (in_valid) begin
`ifdef EXEC_ALU_MUL_EN
            if (func == OP_MUL) begin
                prod_d   = '0;
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                cnt_d    = '0;
                state_d  = ST_MUL;
            end else
`endif
            begin
                result_d = op_res;
                c_d      = op_c;
                if (op_zn) begin
                    z_d = is_zero(op_res);
                    n_d = sign_of(op_res);
                end
                state_d = ST_EXEC;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Control state, result and flags; reset clears them without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
`ifdef EXEC_ALU_MUL_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
`ifdef EXEC_ALU_MUL_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

`ifdef EXEC_ALU_MUL_EN
    // Multiplier working registers; always loaded before use, so no reset.
    always_ff @(posedge clk) begin
        prod_q   <= prod_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end
`endif

    assign in_ready  = reset && (state_q != ST_MUL);
    assign out_valid = (state_q == ST_EXEC);
    assign result    = result_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
`ifdef EXEC_ALU_MUL_EN
    assign busy      = (state_q == ST_MUL);
`else
    assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_exec_alu_param.sv
// Testbench for exec_alu_param (WIDTH=16): directed cases plus randomized
// traffic against a cycle-level reference model of the ALU's rules.
module tb_exec_alu_param;

    localparam int     W     = 16;
    localparam int     SH    = $clog2(W);
    localparam longint MASK  = (64'd1 << W) - 1;
`ifdef EXEC_ALU_MUL_EN
    localparam bit     MUL_EN = 1'b1;
`else
    localparam bit     MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic         flag_c;
    logic         flag_z;
    logic         flag_n;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    longint m_res;
    bit     m_c, m_z, m_n, m_ov;
    int     m_left;
    longint m_ma, m_mb;

    exec_alu_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one single-cycle opcode to the model from the ALU's stated rules.
    task automatic model_op(input logic [3:0] f, input longint x, input longint y);
        longint r;
        int     amt;
        bit     zn;
        r   = m_res;
        zn  = 1'b0;
        amt = int'(y) & ((1 << SH) - 1);
        case (f)
            4'h1, 4'h2: r = x;
            4'h3: begin r = x + y; m_c = (r > MASK); r = r & MASK; zn = 1'b1; end
            4'h4: begin r = (~y) & MASK; zn = 1'b1; end
            4'h6: begin m_c = (x < y); r = (x - y) & MASK; zn = 1'b1; end
            4'h7: begin r = x & y; zn = 1'b1; end
            4'h8: begin r = x | y; zn = 1'b1; end
            4'h9: begin r = x + 1; m_c = (r > MASK); r = r & MASK; zn = 1'b1; end
            4'hA: begin m_c = (x == 0); r = (x - 1) & MASK; zn = 1'b1; end
            4'hB: begin
                m_c = (amt == 0) ? 1'b0 : (((x >> (W - amt)) & 1) != 0);
                r   = (x << amt) & MASK;
                zn  = 1'b1;
            end
            4'hC: begin
                m_c = (amt == 0) ? 1'b0 : (((x >> (amt - 1)) & 1) != 0);
                r   = x >> amt;
                zn  = 1'b1;
            end
            4'hD: m_c = 1'b1;
            4'hE: m_c = 1'b0;
            default: ;
        endcase
        m_res = r;
        if (zn) begin
            m_z = (r == 0);
            m_n = ((r >> (W - 1)) & 1) != 0;
        end
    endtask

    // What one rising edge does to the model, given the inputs it sampled.
    task automatic model_edge(input logic v, input logic [3:0] f, input longint x,
                              input longint y, input logic fl);
        longint p;
        m_ov = 1'b0;
        if (fl) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                p     = m_ma * m_mb;
                m_res = p & MASK;
                m_c   = (p >> W) != 0;
                m_z   = (m_res == 0);
                m_n   = ((m_res >> (W - 1)) & 1) != 0;
                m_ov  = 1'b1;
            end
        end else if (v) begin
            if (f == 4'hF && MUL_EN) begin
                m_left = W;
                m_ma   = x;
                m_mb   = y;
            end else begin
                model_op(f, x, y);
                m_ov = 1'b1;
            end
        end
    endtask

    // Drive one cycle, check handshake before the edge and outputs after it.
    task automatic cyc(input logic v, input logic [3:0] f, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic fl);
        in_valid = v;
        func     = f;
        a        = ia;
        b        = ib;
        flush    = fl;
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_left == 0));
        @(posedge clk);
        model_edge(v, f, longint'(ia), longint'(ib), fl);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("result", 32'(result), 32'(m_res));
        chk("flag_c", 32'(flag_c), 32'(m_c));
        chk("flag_z", 32'(flag_z), 32'(m_z));
        chk("flag_n", 32'(flag_n), 32'(m_n));
        chk("busy", 32'(busy), 32'(m_left > 0));
    endtask

    // Pulse reset between edges and confirm outputs clear without a clock.
    task automatic async_reset_pulse();
        reset = 1'b0;
        #1;
        chk("arst_result", 32'(result), 32'h0);
        chk("arst_c", 32'(flag_c), 32'h0);
        chk("arst_z", 32'(flag_z), 32'h0);
        chk("arst_n", 32'(flag_n), 32'h0);
        chk("arst_ov", 32'(out_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        m_res = 0; m_c = 0; m_z = 0; m_n = 0; m_ov = 0; m_left = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return W'(1) << (W - 1);
            3: return ~(W'(1) << (W - 1));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; func = 4'h0; a = '0; b = '0;
        m_res = 0; m_c = 0; m_z = 0; m_n = 0; m_ov = 0; m_left = 0; m_ma = 0; m_mb = 0;
        #2;
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_flags", 32'({flag_c, flag_z, flag_n}), 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h1);

        // Directed sequence with hand-derived expectations.
        cyc(1'b1, 4'h3, 16'hFFFF, 16'h0001, 1'b0);
        chk("add_ov", 32'(out_valid), 32'h1);
        chk("add_res", 32'(result), 32'h0000);
        chk("add_czn", 32'({flag_c, flag_z, flag_n}), 32'b110);
        cyc(1'b1, 4'h6, 16'h0003, 16'h0005, 1'b0);
        chk("sub_res", 32'(result), 32'hFFFE);
        chk("sub_czn", 32'({flag_c, flag_z, flag_n}), 32'b101);
        cyc(1'b1, 4'h1, 16'h1234, 16'h0000, 1'b0);
        chk("ldd_res", 32'(result), 32'h1234);
        chk("ldd_czn", 32'({flag_c, flag_z, flag_n}), 32'b101);
        cyc(1'b1, 4'hB, 16'h8001, 16'h0001, 1'b0);
        chk("shl_res", 32'(result), 32'h0002);
        chk("shl_c", 32'(flag_c), 32'h1);
        cyc(1'b1, 4'hC, 16'h0001, 16'h0000, 1'b0);
        chk("shr_res", 32'(result), 32'h0001);
        chk("shr_c", 32'(flag_c), 32'h0);
        cyc(1'b1, 4'h9, 16'h7FFF, 16'h0000, 1'b0);
        chk("inc_res", 32'(result), 32'h8000);
        chk("inc_cn", 32'({flag_c, flag_n}), 32'b01);
        cyc(1'b1, 4'hA, 16'h0000, 16'h0000, 1'b0);
        chk("dec_res", 32'(result), 32'hFFFF);
        chk("dec_c", 32'(flag_c), 32'h1);
        cyc(1'b1, 4'h4, 16'h0000, 16'h00FF, 1'b0);
        chk("not_ov", 32'(out_valid), 32'h1);
        chk("not_res", 32'(result), 32'hFF00);
        chk("not_c", 32'(flag_c), 32'h1);
        cyc(1'b0, 4'h3, 16'h0001, 16'h0001, 1'b0);
        chk("idle_ov", 32'(out_valid), 32'h0);
        cyc(1'b1, 4'h3, 16'h0001, 16'h0001, 1'b1);
        chk("flush_win_ov", 32'(out_valid), 32'h0);
        chk("flush_win_res", 32'(result), 32'hFF00);
        cyc(1'b1, 4'hE, 16'h0000, 16'h0000, 1'b0);
        chk("clrc_czn", 32'({flag_c, flag_z, flag_n}), 32'b001);
        cyc(1'b1, 4'hD, 16'h0000, 16'h0000, 1'b0);
        chk("setc_res", 32'(result), 32'hFF00);
        chk("setc_c", 32'(flag_c), 32'h1);
        cyc(1'b1, 4'h5, 16'h0001, 16'h0001, 1'b0);
        chk("nop_ov", 32'(out_valid), 32'h1);
        chk("nop_res", 32'(result), 32'hFF00);
        cyc(1'b1, 4'h2, 16'h0000, 16'h0000, 1'b0);
        chk("std_res", 32'(result), 32'h0000);
        chk("std_zn", 32'({flag_z, flag_n}), 32'b01);

`ifdef EXEC_ALU_MUL_EN
        // 0x0100 * 0x0100 = 0x1_0000; a competing ADD is held off until done.
        cyc(1'b1, 4'hF, 16'h0100, 16'h0100, 1'b0);
        chk("mul_busy", 32'(busy), 32'h1);
        for (int i = 0; i < W; i++) cyc(1'b1, 4'h3, 16'h0001, 16'h0001, 1'b0);
        chk("mul_ov", 32'(out_valid), 32'h1);
        chk("mul_res", 32'(result), 32'h0000);
        chk("mul_cz", 32'({flag_c, flag_z}), 32'b11);
        cyc(1'b1, 4'h3, 16'h0001, 16'h0001, 1'b0);
        chk("post_mul_add", 32'(result), 32'h0002);
        // Flush five cycles into a multiply.
        cyc(1'b1, 4'hF, 16'h0123, 16'h0045, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        cyc(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1);
        chk("mflush_busy", 32'(busy), 32'h0);
        chk("mflush_ov", 32'(out_valid), 32'h0);
        chk("mflush_res", 32'(result), 32'h0002);
        for (int i = 0; i < W + 2; i++) cyc(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        // Reset in the middle of a multiply.
        cyc(1'b1, 4'hF, 16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        async_reset_pulse();
`else
        cyc(1'b1, 4'hF, 16'h1111, 16'h2222, 1'b0);
        chk("op15_ov", 32'(out_valid), 32'h1);
        chk("op15_res", 32'(result), 32'h0000);
        chk("op15_busy", 32'(busy), 32'h0);
        cyc(1'b1, 4'h7, 16'hFFFF, 16'h00F0, 1'b0);
        chk("and_res", 32'(result), 32'h00F0);
        async_reset_pulse();
`endif
        cyc(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                rand_val(), rand_val(), ($urandom_range(0, 24) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
